// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned
// operands, RISC-V style results for divide-by-zero and signed overflow.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder, always < |divisor|
   logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
   logic             negq_q, negq_d;   // quotient must be negated in FIX
   logic             negr_q, negr_d;   // remainder must be negated in FIX
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;

   // The shifted remainder can reach 2*|divisor|-1, so the trial compare
   // needs one extra bit; the subtracted result always fits back in WIDTH.
   logic [WIDTH:0]   shifted;
   logic             ge;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
      return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
   endfunction

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state logic: operand capture, shift-subtract iteration, sign fix-up
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      shifted = {rem_q, quo_q[WIDTH-1]};
      ge      = (shifted >= {1'b0, dvs_q});

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               if (divisor == '0) begin
                  // Result is immediate; the iteration is skipped entirely
                  quot_d  = '1;
                  remo_d  = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = mag(dividend, is_signed);
                  dvs_d   = mag(divisor, is_signed);
                  negq_d  = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  negr_d  = is_signed && dividend[WIDTH-1];
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            rem_d = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            // Overflow (-2^(W-1) / -1) needs no special case: the magnitude
            // quotient 2^(W-1) with no negation is the required result.
            quot_d  = negq_q ? (~quo_q + 1'b1) : quo_q;
            remo_d  = negr_q ? (~rem_q + 1'b1) : rem_q;
            dbz_d   = 1'b0;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q == RUN) || (state_q == FIX);
   assign done        = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = remo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH=32): latency, busy length,
// signed/unsigned results, divide-by-zero, overflow, back-to-back, reset abort.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] last_q = 32'h0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   // Drive operands and a one-cycle start pulse; returns on the negedge after
   // the sampling edge.
   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
      is_signed = s;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Wait for done counting edges from the start-sampling edge (inclusive) and
   // busy cycles. inj=1: pulse start (9/3) mid-run; inj=2: reset at edge 10.
   task automatic await(input string tag, input int exp_edges, input int exp_busy,
                        input logic [31:0] eq, input logic [31:0] er, input logic ed,
                        input int inj);
      int e;
      int nb;
      e  = 1;
      nb = 0;
      while (!done && e < 100) begin
         if (busy) nb++;
         if (e == 17) check_eq({tag, " hold_q"}, quotient, last_q);
         if (inj == 1 && e == 5) begin
            dividend = 32'd9;
            divisor  = 32'd3;
            start    = 1'b1;
         end
         if (inj == 1 && e == 6) start = 1'b0;
         if (inj == 2 && e == 10) begin
            reset_n = 1'b0;
            @(negedge clk);
            check_eq({tag, " rst busy"}, {31'b0, busy}, 32'd0);
            check_eq({tag, " rst done"}, {31'b0, done}, 32'd0);
            check_eq({tag, " rst q"}, quotient, 32'd0);
            check_eq({tag, " rst r"}, remainder, 32'd0);
            check_eq({tag, " rst dbz"}, {31'b0, div_by_zero}, 32'd0);
            reset_n = 1'b1;
            last_q  = 32'h0;
            nb = 0;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (done || busy) nb++;
            end
            check_eq({tag, " no done after abort"}, nb, 32'd0);
            return;
         end
         @(negedge clk);
         e++;
      end
      check_eq({tag, " edges"}, e, exp_edges);
      check_eq({tag, " busy cycles"}, nb, exp_busy);
      check_eq({tag, " q"}, quotient, eq);
      check_eq({tag, " r"}, remainder, er);
      check_eq({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, ed});
      last_q = eq;
   endtask

   task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er, input logic ed);
      issue(s, a, b);
      if (ed) await(tag, 1, 0, eq, er, ed, 0);
      else    await(tag, 34, 33, eq, er, ed, 0);
      @(negedge clk);
      check_eq({tag, " done pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(negedge clk);
      check_eq("reset busy", {31'b0, busy}, 32'd0);
      check_eq("reset done", {31'b0, done}, 32'd0);
      check_eq("reset q", quotient, 32'd0);
      check_eq("reset r", remainder, 32'd0);
      check_eq("reset dbz", {31'b0, div_by_zero}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      run("u 100/7",        1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
      run("s -100/7",       1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
      run("s 100/-7",       1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0);
      run("s -100/-7",      1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0);
      run("s 7/100",        1'b1, 32'd7,        32'd100,      32'd0,        32'd7,        1'b0);
      run("u dbz",          1'b0, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1);
      run("s dbz",          1'b1, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1);
      run("s overflow",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
      run("u 8000_0000/max",1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
      run("u max/1",        1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0);

      // start pulse while busy must be ignored
      issue(1'b0, 32'd100, 32'd7);
      await("ignore busy start", 34, 33, 32'd14, 32'd2, 1'b0, 1);
      // back-to-back: issue during the DONE cycle
      issue(1'b0, 32'd1000, 32'd3);
      await("back2back", 34, 33, 32'd333, 32'd1, 1'b0, 0);
      @(negedge clk);

      // reset mid-run, then a normal op completes
      issue(1'b0, 32'd100, 32'd7);
      await("abort", 34, 33, 32'd14, 32'd2, 1'b0, 2);
      run("after reset",    1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
